// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-lite arbiter: round-robin with a per-grant beat budget,
// lock support and parking on M0. Address/control follow the address-phase
// owner; write data follows the data-phase owner one hready edge later.
module ahb_master_arbiter #(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_hbusreq,
  input  logic        m1_hbusreq,
  input  logic        m0_hlock,
  input  logic        m1_hlock,
  input  logic [31:0] m0_haddr,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic [1:0]  m1_htrans,
  input  logic        m0_hwrite,
  input  logic        m1_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m1_hsize,
  input  logic [3:0]  m0_hprot,
  input  logic [3:0]  m1_hprot,
  input  logic        m0_is_signed,
  input  logic        m1_is_signed,
  input  logic [31:0] m0_hwdata,
  input  logic [31:0] m1_hwdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        m0_hgrant,
  output logic        m1_hgrant,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic        is_signed,
  output logic [31:0] hwdata,
  output logic        hmastlock,
  output logic        hmaster,
  output logic        hmaster_data
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  owner_e        g;
  owner_e        g_nxt;
  logic [CW-1:0] cnt;
  logic          cur_lock;
  logic          cur_req;
  logic          oth_req;
  logic          beat;
  logic          hresp_unused;

  // Error responses go straight to the masters; arbitration ignores them.
  assign hresp_unused = hresp;

  assign m0_hgrant = (g == OWN_M0);
  assign m1_hgrant = (g == OWN_M1);

  // Address/control mux on the address-phase owner; htrans idles in reset.
  always_comb begin
    if (hmaster) begin
      haddr     = m1_haddr;
      htrans    = m1_htrans;
      hwrite    = m1_hwrite;
      hsize     = m1_hsize;
      hprot     = m1_hprot;
      is_signed = m1_is_signed;
    end else begin
      haddr     = m0_haddr;
      htrans    = m0_htrans;
      hwrite    = m0_hwrite;
      hsize     = m0_hsize;
      hprot     = m0_hprot;
      is_signed = m0_is_signed;
    end
    if (!reset) begin
      htrans = '0;
    end
  end

  // Write data mux on the data-phase owner.
  always_comb begin
    hwdata = hmaster_data ? m1_hwdata : m0_hwdata;
  end

  // Next-grant decision: lock holds, budget/release hands over, idle parks on M0.
  always_comb begin
    cur_lock = (g == OWN_M1) ? m1_hlock   : m0_hlock;
    cur_req  = (g == OWN_M1) ? m1_hbusreq : m0_hbusreq;
    oth_req  = (g == OWN_M1) ? m0_hbusreq : m1_hbusreq;
    beat     = (hmaster == logic'(g)) && htrans[1];
    g_nxt    = g;
    if (cur_lock) begin
      g_nxt = g;
    end else if (oth_req && (!cur_req || (cnt >= CNT_MAX))) begin
      g_nxt = (g == OWN_M0) ? OWN_M1 : OWN_M0;
    end else if (!m0_hbusreq && !m1_hbusreq) begin
      g_nxt = OWN_M0;
    end
  end

  // Ownership pipeline and beat budget, advancing only on completed transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g            <= OWN_M0;
      hmaster      <= 1'b0;
      hmaster_data <= 1'b0;
      hmastlock    <= 1'b0;
      cnt          <= '0;
    end else if (hready) begin
      hmaster_data <= hmaster;
      hmaster      <= logic'(g);
      hmastlock    <= cur_lock;
      g            <= g_nxt;
      if (g_nxt != g) begin
        cnt <= '0;
      end else if (beat && (cnt < CNT_MAX)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed vector table, hand-written lock and
// reset sequences, then randomized traffic against a behavioural model.
module tb_ahb_master_arbiter;

  localparam int unsigned BM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_hbusreq, m1_hbusreq, m0_hlock, m1_hlock;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, m0_is_signed, m1_is_signed;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        hready, hresp;
  logic        m0_hgrant, m1_hgrant, hwrite, is_signed, hmastlock, hmaster, hmaster_data;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;

  int checks = 0;
  int errors = 0;

  ahb_master_arbiter #(.BURST_MAX(BM)) dut (
    .clk(clk), .reset(rst_n),
    .m0_hbusreq(m0_hbusreq), .m1_hbusreq(m1_hbusreq),
    .m0_hlock(m0_hlock), .m1_hlock(m1_hlock),
    .m0_haddr(m0_haddr), .m1_haddr(m1_haddr),
    .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
    .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite),
    .m0_hsize(m0_hsize), .m1_hsize(m1_hsize),
    .m0_hprot(m0_hprot), .m1_hprot(m1_hprot),
    .m0_is_signed(m0_is_signed), .m1_is_signed(m1_is_signed),
    .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
    .hready(hready), .hresp(hresp),
    .m0_hgrant(m0_hgrant), .m1_hgrant(m1_hgrant),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hprot(hprot), .is_signed(is_signed), .hwdata(hwdata),
    .hmastlock(hmastlock), .hmaster(hmaster), .hmaster_data(hmaster_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: owners as integers, requests/locks as per-master arrays.
  int mg = 0, mam = 0, mdm = 0, mbeats = 0;
  bit mlk = 1'b0;

  function automatic int pick_owner(int cur, int beats);
    bit rq[2];
    bit lk[2];
    int oth;
    rq[0] = m0_hbusreq; rq[1] = m1_hbusreq;
    lk[0] = m0_hlock;   lk[1] = m1_hlock;
    oth = 1 - cur;
    if (lk[cur]) return cur;
    if (rq[oth] && (!rq[cur] || beats >= int'(BM))) return oth;
    if (!rq[0] && !rq[1]) return 0;
    return cur;
  endfunction

  function automatic int addr_trans();
    return (mam == 1) ? int'(m1_htrans) : int'(m0_htrans);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mg <= 0; mam <= 0; mdm <= 0; mlk <= 1'b0; mbeats <= 0;
    end else if (hready) begin
      int nxt;
      nxt = pick_owner(mg, mbeats);
      if (nxt != mg) mbeats <= 0;
      else if (mam == mg && addr_trans() >= 2) mbeats <= (mbeats + 1 > int'(BM)) ? int'(BM) : mbeats + 1;
      mlk <= (mg == 1) ? m1_hlock : m0_hlock;
      mdm <= mam;
      mam <= mg;
      mg  <= nxt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("m0_hgrant", 32'(m0_hgrant), 32'(mg == 0));
    chk("m1_hgrant", 32'(m1_hgrant), 32'(mg == 1));
    chk("hmaster", 32'(hmaster), 32'(mam));
    chk("hmaster_data", 32'(hmaster_data), 32'(mdm));
    chk("hmastlock", 32'(hmastlock), 32'(mlk));
    chk("haddr", haddr, (mam == 1) ? m1_haddr : m0_haddr);
    chk("htrans", 32'(htrans), rst_n ? 32'(addr_trans()) : 32'd0);
    chk("hwrite", 32'(hwrite), 32'((mam == 1) ? m1_hwrite : m0_hwrite));
    chk("hsize", 32'(hsize), 32'((mam == 1) ? m1_hsize : m0_hsize));
    chk("hprot", 32'(hprot), 32'((mam == 1) ? m1_hprot : m0_hprot));
    chk("is_signed", 32'(is_signed), 32'((mam == 1) ? m1_is_signed : m0_is_signed));
    chk("hwdata", hwdata, (mdm == 1) ? m1_hwdata : m0_hwdata);
  endtask

  typedef struct {
    bit       r0, r1, l0, l1, rdy;
    logic [1:0] t0, t1;
    bit       e_g, e_hm, e_hd;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int r0, input int r1, input int l0, input int l1, input int rdy,
                         input int t0, input int t1, input int eg, input int ehm, input int ehd);
    vec_t v;
    v.r0 = (r0 != 0); v.r1 = (r1 != 0); v.l0 = (l0 != 0); v.l1 = (l1 != 0);
    v.rdy = (rdy != 0); v.t0 = 2'(t0); v.t1 = 2'(t1);
    v.e_g = (eg != 0); v.e_hm = (ehm != 0); v.e_hd = (ehd != 0);
    tbl.push_back(v);
  endtask

  task automatic drive(input bit r0, input bit r1, input bit l0, input bit l1, input bit rdy,
                       input logic [1:0] t0, input logic [1:0] t1);
    m0_hbusreq = r0; m1_hbusreq = r1; m0_hlock = l0; m1_hlock = l1;
    hready = rdy; m0_htrans = t0; m1_htrans = t1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] ID = 2'b00, NS = 2'b10, SQ = 2'b11;

  initial begin
    rst_n = 1'b0;
    m0_haddr = 32'hA000_0010; m1_haddr = 32'hB000_0020;
    m0_hwdata = 32'hD0D0_0001; m1_hwdata = 32'hD1D1_0002;
    m0_hwrite = 1'b1; m1_hwrite = 1'b0;
    m0_hsize = 3'd2; m1_hsize = 3'd1;
    m0_hprot = 4'h3; m1_hprot = 4'hC;
    m0_is_signed = 1'b0; m1_is_signed = 1'b1;
    hresp = 1'b0;
    drive(1, 1, 0, 0, 1, NS, SQ);

    // Reset with both requesting
    #12;
    chk("rst_m0_hgrant", 32'(m0_hgrant), 32'd1);
    chk("rst_m1_hgrant", 32'(m1_hgrant), 32'd0);
    chk("rst_hmaster", 32'(hmaster), 32'd0);
    chk("rst_hmaster_data", 32'(hmaster_data), 32'd0);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hmastlock", 32'(hmastlock), 32'd0);
    chk("rst_haddr", haddr, 32'hA000_0010);
    tick();
    rst_n = 1'b1;

    //       r0 r1 l0 l1 rdy t0  t1   g hm hd
    add_vec(1, 1, 0, 0, 1, 2, 0,  0, 0, 0);  // M0 holds after release
    add_vec(0, 1, 0, 0, 1, 0, 2,  1, 0, 0);  // M1-only request: grant
    add_vec(0, 1, 0, 0, 1, 0, 2,  1, 1, 0);  // address ownership
    add_vec(0, 1, 0, 0, 1, 0, 3,  1, 1, 1);  // data ownership
    add_vec(1, 0, 0, 0, 1, 2, 0,  0, 1, 1);  // M1 releases, M0 granted
    add_vec(1, 0, 0, 0, 1, 2, 0,  0, 0, 1);
    add_vec(1, 1, 0, 0, 1, 2, 0,  0, 0, 0);  // budget not spent: M0 holds
    add_vec(0, 1, 0, 0, 1, 0, 2,  1, 0, 0);  // m1_hgrant rises
    add_vec(0, 1, 0, 0, 0, 0, 2,  1, 0, 0);  // wait states freeze all
    add_vec(0, 1, 0, 0, 0, 0, 2,  1, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0, 2,  1, 0, 0);
    add_vec(0, 1, 0, 0, 1, 0, 2,  1, 1, 0);
    add_vec(0, 1, 0, 0, 1, 0, 3,  1, 1, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].rdy, tbl[i].t0, tbl[i].t1);
      tick();
      chk($sformatf("vec%0d_m0_hgrant", i), 32'(m0_hgrant), 32'(!tbl[i].e_g));
      chk($sformatf("vec%0d_m1_hgrant", i), 32'(m1_hgrant), 32'(tbl[i].e_g));
      chk($sformatf("vec%0d_hmaster", i), 32'(hmaster), 32'(tbl[i].e_hm));
      chk($sformatf("vec%0d_hmaster_data", i), 32'(hmaster_data), 32'(tbl[i].e_hd));
      chk($sformatf("vec%0d_haddr", i), haddr, tbl[i].e_hm ? 32'hB000_0020 : 32'hA000_0010);
      chk($sformatf("vec%0d_htrans", i), 32'(htrans), 32'(tbl[i].e_hm ? tbl[i].t1 : tbl[i].t0));
      chk($sformatf("vec%0d_hwdata", i), hwdata, tbl[i].e_hd ? 32'hD1D1_0002 : 32'hD0D0_0001);
    end

    // Lock: M1 keeps grant through 6 beats despite M0 requesting
    drive(1, 1, 0, 1, 1, NS, SQ);
    for (int b = 0; b < 6; b++) begin
      tick();
      chk($sformatf("lock%0d_m1_hgrant", b), 32'(m1_hgrant), 32'd1);
      chk($sformatf("lock%0d_hmastlock", b), 32'(hmastlock), 32'd1);
      chk($sformatf("lock%0d_hmaster", b), 32'(hmaster), 32'd1);
    end
    drive(1, 1, 0, 0, 1, NS, SQ);
    tick();
    chk("unlock_m0_hgrant", 32'(m0_hgrant), 32'd1);
    chk("unlock_hmastlock", 32'(hmastlock), 32'd0);
    tick();
    chk("unlock_hmaster", 32'(hmaster), 32'd0);
    chk("unlock_hmaster_data", 32'(hmaster_data), 32'd1);

    // Reset mid-burst during an M1 SEQ beat
    drive(0, 1, 0, 0, 1, ID, SQ);
    tick(); tick(); tick();
    chk("mid_m1_hgrant", 32'(m1_hgrant), 32'd1);
    chk("mid_hmaster", 32'(hmaster), 32'd1);
    chk("mid_hmaster_data", 32'(hmaster_data), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_m0_hgrant", 32'(m0_hgrant), 32'd1);
    chk("midrst_hmaster", 32'(hmaster), 32'd0);
    chk("midrst_hmaster_data", 32'(hmaster_data), 32'd0);
    chk("midrst_htrans", 32'(htrans), 32'd0);
    chk("midrst_hwdata", hwdata, 32'hD0D0_0001);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, ID, ID);
    tick();
    chk("park_m0_hgrant", 32'(m0_hgrant), 32'd1);
    chk("park_m1_hgrant", 32'(m1_hgrant), 32'd0);

    // Fairness: both request continuously with full-speed beats
    drive(1, 1, 0, 0, 1, NS, SQ);
    for (int c = 0; c < 30; c++) begin
      tick();
      check_all();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      m0_hbusreq = ($urandom_range(0, 3) != 0);
      m1_hbusreq = ($urandom_range(0, 3) != 0);
      m0_hlock   = m0_hbusreq && ($urandom_range(0, 9) == 0);
      m1_hlock   = m1_hbusreq && ($urandom_range(0, 9) == 0);
      hready     = ($urandom_range(0, 3) != 0);
      hresp      = ($urandom_range(0, 15) == 0);
      m0_htrans  = 2'($urandom_range(0, 3));
      m1_htrans  = 2'($urandom_range(0, 3));
      m0_haddr   = $urandom;  m1_haddr  = $urandom;
      m0_hwdata  = $urandom;  m1_hwdata = $urandom;
      m0_hwrite  = 1'($urandom_range(0, 1));
      m1_hwrite  = 1'($urandom_range(0, 1));
      m0_hsize   = 3'($urandom_range(0, 7));
      m1_hsize   = 3'($urandom_range(0, 7));
      m0_hprot   = 4'($urandom_range(0, 15));
      m1_hprot   = 4'($urandom_range(0, 15));
      m0_is_signed = 1'($urandom_range(0, 1));
      m1_is_signed = 1'($urandom_range(0, 1));
      #1;
      check_all();
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
